// File: rtl/bp_cce_pkg.sv
// Shared CCE types: coherence states, directory-reader FSM states, and the
// directory entry layout macro (tag width varies per instance).
`ifndef BP_CCE_PKG_SV
`define BP_CCE_PKG_SV

`define BP_CCE_DECLARE_DIR_ENTRY_S(tag_width_mp) \
   typedef struct packed { \
      logic [tag_width_mp-1:0] tag; \
      bp_coh_states_e          state; \
   } bp_cce_dir_entry_s

package bp_cce_pkg;

   typedef enum logic [2:0] {
      e_COH_I = 3'b000,
      e_COH_S = 3'b001,
      e_COH_E = 3'b010,
      e_COH_F = 3'b011,
      e_COH_M = 3'b110,
      e_COH_O = 3'b111
   } bp_coh_states_e;

   typedef enum logic [1:0] {
      e_rd_ready,
      e_rd_issue,
      e_rd_drain,
      e_rd_done
   } bp_cce_dir_rd_state_e;

   localparam int unsigned coh_state_width_gp = $bits(bp_coh_states_e);

   // clog2 that never returns 0, so single-element fields stay 1 bit wide
   function automatic int unsigned safe_clog2(input int unsigned x);
      return (x <= 1) ? 1 : $clog2(x);
   endfunction

endpackage

`endif

// File: rtl/bp_cce_dir_tag_checker.sv
// Combinational tag match over one directory row; the lowest matching valid
// way wins.
module bp_cce_dir_tag_checker
   import bp_cce_pkg::*;
 #(parameter  int unsigned lce_assoc_p     = 8,
   parameter  int unsigned tag_width_p     = 10,
   localparam int unsigned lg_lce_assoc_lp = safe_clog2(lce_assoc_p),
   localparam int unsigned entry_width_lp  = tag_width_p + coh_state_width_gp)
  (input  logic [lce_assoc_p*entry_width_lp-1:0] row_i,
   input  logic [tag_width_p-1:0]                tag_i,
   output logic                                  hit_o,
   output logic [lg_lce_assoc_lp-1:0]            way_o,
   output bp_coh_states_e                        state_o);

   `BP_CCE_DECLARE_DIR_ENTRY_S(tag_width_p);

   bp_cce_dir_entry_s [lce_assoc_p-1:0] entries;
   logic [lce_assoc_p-1:0]              match;

   assign entries = row_i;

   // an entry in state I never counts as a hit, even with a matching tag
   always_comb begin
      match = '0;
      for (int unsigned w = 0; w < lce_assoc_p; w++) begin
         match[w] = (entries[w].tag == tag_i) && (entries[w].state != e_COH_I);
      end
   end

   // descending scan leaves the lowest matching way as the final assignment
   always_comb begin
      hit_o   = |match;
      way_o   = '0;
      state_o = e_COH_I;
      for (int w = int'(lce_assoc_p) - 1; w >= 0; w--) begin
         if (match[w]) begin
            way_o   = lg_lce_assoc_lp'(w);
            state_o = entries[w].state;
         end
      end
   end

endmodule

// File: rtl/bp_cce_dir_rd.sv
// Directory way-group reader: streams every LCE row of one way-group out of
// the directory RAM and consolidates per-LCE hit/way/state sharer vectors.
module bp_cce_dir_rd
   import bp_cce_pkg::*;
 #(parameter  int unsigned num_lce_p            = 4,
   parameter  int unsigned lce_assoc_p          = 8,
   parameter  int unsigned num_way_groups_p     = 8,
   parameter  int unsigned tag_width_p          = 10,
   localparam int unsigned lg_num_lce_lp        = safe_clog2(num_lce_p),
   localparam int unsigned lg_lce_assoc_lp      = safe_clog2(lce_assoc_p),
   localparam int unsigned lg_num_way_groups_lp = safe_clog2(num_way_groups_p),
   localparam int unsigned coh_w_lp             = coh_state_width_gp,
   localparam int unsigned entry_width_lp       = tag_width_p + coh_w_lp,
   localparam int unsigned addr_width_lp        = lg_num_way_groups_lp + lg_num_lce_lp)
  (input  logic                                   clk_i,
   input  logic                                   reset_i,
   input  logic                                   rd_v_i,
   output logic                                   rd_ready_o,
   input  logic [lg_num_way_groups_lp-1:0]        wg_id_i,
   input  logic [tag_width_p-1:0]                 tag_i,
   output logic                                   ram_v_o,
   output logic [addr_width_lp-1:0]               ram_addr_o,
   input  logic [lce_assoc_p*entry_width_lp-1:0]  ram_data_i,
   output logic                                   sharers_v_o,
   output logic [num_lce_p-1:0]                   sharers_hits_o,
   output logic [num_lce_p*lg_lce_assoc_lp-1:0]   sharers_ways_o,
   output logic [num_lce_p*coh_w_lp-1:0]          sharers_coh_states_o);

   localparam logic [lg_num_lce_lp-1:0] last_lce_lp = lg_num_lce_lp'(num_lce_p - 1);

   bp_cce_dir_rd_state_e state_q, state_d;

   logic [lg_num_way_groups_lp-1:0] wg_id_q, wg_id_d;
   logic [tag_width_p-1:0]          tag_q, tag_d;
   logic [lg_num_lce_lp-1:0]        cnt_q, cnt_d;
   logic [lg_num_lce_lp-1:0]        cnt_r_q, cnt_r_d;
   logic                            ram_v_q, ram_v_d;

   logic [num_lce_p-1:0]                      hits_q, hits_d;
   logic [num_lce_p-1:0][lg_lce_assoc_lp-1:0] ways_q, ways_d;
   logic [num_lce_p-1:0][coh_w_lp-1:0]        states_q, states_d;

   logic                       row_hit;
   logic [lg_lce_assoc_lp-1:0] row_way;
   bp_coh_states_e             row_state;
   logic                       accept;

   bp_cce_dir_tag_checker
    #(.lce_assoc_p (lce_assoc_p),
      .tag_width_p (tag_width_p))
    tag_checker
     (.row_i   (ram_data_i),
      .tag_i   (tag_q),
      .hit_o   (row_hit),
      .way_o   (row_way),
      .state_o (row_state));

   // state register
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) state_q <= e_rd_ready;
      else         state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         e_rd_ready: if (rd_v_i) state_d = e_rd_issue;
         e_rd_issue: if (cnt_q == last_lce_lp) state_d = e_rd_drain;
         e_rd_drain: state_d = e_rd_done;
         e_rd_done:  if (rd_v_i) state_d = e_rd_issue;
         default:    state_d = e_rd_ready;
      endcase
   end

   // FSM outputs
   always_comb begin
      rd_ready_o  = 1'b0;
      ram_v_o     = 1'b0;
      sharers_v_o = 1'b0;
      unique case (state_q)
         e_rd_ready: rd_ready_o = 1'b1;
         e_rd_issue: ram_v_o    = 1'b1;
         e_rd_drain: ;
         e_rd_done: begin
            rd_ready_o  = 1'b1;
            sharers_v_o = 1'b1;
         end
         default: ;
      endcase
   end

   assign accept               = rd_ready_o & rd_v_i;
   assign ram_addr_o           = {wg_id_q, cnt_q};
   assign sharers_hits_o       = hits_q;
   assign sharers_ways_o       = ways_q;
   assign sharers_coh_states_o = states_q;

   // request latch, row counter and sharer-vector consolidation
   always_comb begin
      wg_id_d  = wg_id_q;
      tag_d    = tag_q;
      cnt_d    = cnt_q;
      cnt_r_d  = cnt_r_q;
      ram_v_d  = ram_v_o;
      hits_d   = hits_q;
      ways_d   = ways_q;
      states_d = states_q;

      if (ram_v_o) cnt_r_d = cnt_q;

      // RAM data returns one cycle after the read; a miss writes zeros
      if (ram_v_q) begin
         hits_d[cnt_r_q]   = row_hit;
         ways_d[cnt_r_q]   = row_way;
         states_d[cnt_r_q] = row_state;
      end

      if ((state_q == e_rd_issue) && (cnt_q != last_lce_lp)) cnt_d = cnt_q + 1'b1;

      if (accept) begin
         wg_id_d  = wg_id_i;
         tag_d    = tag_i;
         cnt_d    = '0;
         hits_d   = '0;
         ways_d   = '0;
         states_d = '0;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wg_id_q  <= '0;
         tag_q    <= '0;
         cnt_q    <= '0;
         cnt_r_q  <= '0;
         ram_v_q  <= 1'b0;
         hits_q   <= '0;
         ways_q   <= '0;
         states_q <= '0;
      end else begin
         wg_id_q  <= wg_id_d;
         tag_q    <= tag_d;
         cnt_q    <= cnt_d;
         cnt_r_q  <= cnt_r_d;
         ram_v_q  <= ram_v_d;
         hits_q   <= hits_d;
         ways_q   <= ways_d;
         states_q <= states_d;
      end
   end

endmodule

// File: tb/tb_bp_cce_dir_rd.sv
// Directed bench for bp_cce_dir_rd (4 LCEs, 8-way, 10-bit tags) with a
// one-cycle-latency directory RAM model.
module tb_bp_cce_dir_rd;
   import bp_cce_pkg::*;

   localparam int unsigned NL = 4;
   localparam int unsigned NA = 8;
   localparam int unsigned NWG = 8;
   localparam int unsigned TW = 10;
   localparam int unsigned EW = TW + 3;

   logic              clk = 1'b0;
   logic              reset_i;
   logic              rd_v_i;
   logic              rd_ready_o;
   logic [2:0]        wg_id_i;
   logic [TW-1:0]     tag_i;
   logic              ram_v_o;
   logic [4:0]        ram_addr_o;
   logic [NA*EW-1:0]  ram_data_i;
   logic              sharers_v_o;
   logic [NL-1:0]     sharers_hits_o;
   logic [NL*3-1:0]   sharers_ways_o;
   logic [NL*3-1:0]   sharers_coh_states_o;

   logic [NA*EW-1:0]  mem [32];

   int passed = 0;
   int total  = 0;

   bp_cce_dir_rd #(.num_lce_p(NL), .lce_assoc_p(NA), .num_way_groups_p(NWG), .tag_width_p(TW)) dut
     (.clk_i                (clk),
      .reset_i              (reset_i),
      .rd_v_i               (rd_v_i),
      .rd_ready_o           (rd_ready_o),
      .wg_id_i              (wg_id_i),
      .tag_i                (tag_i),
      .ram_v_o              (ram_v_o),
      .ram_addr_o           (ram_addr_o),
      .ram_data_i           (ram_data_i),
      .sharers_v_o          (sharers_v_o),
      .sharers_hits_o       (sharers_hits_o),
      .sharers_ways_o       (sharers_ways_o),
      .sharers_coh_states_o (sharers_coh_states_o));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_v_o) ram_data_i <= mem[ram_addr_o];
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish (observed timeout, expected $finish)");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic set_entry(input int a, input int w, input logic [TW-1:0] t, input logic [2:0] s);
      mem[a][w*EW +: EW] = {t, s};
   endtask

   task automatic start_req(input logic [2:0] wg, input logic [TW-1:0] t);
      rd_v_i  = 1'b1;
      wg_id_i = wg;
      tag_i   = t;
      tick();
      rd_v_i  = 1'b0;
   endtask

   // entered at cycle 1 after acceptance; leaves at cycle 6
   task automatic run_burst(input string nm, input int base);
      for (int i = 0; i < 4; i++) begin
         chk({nm, "_ram_v"}, 32'(ram_v_o), 32'd1);
         chk({nm, "_addr"}, 32'(ram_addr_o), 32'(base + i));
         if (i == 0) begin
            wg_id_i = 3'd7;
            tag_i   = 10'h000;
         end
         tick();
      end
      chk({nm, "_ram_v_drain"}, 32'(ram_v_o), 32'd0);
      chk({nm, "_sv_drain"}, 32'(sharers_v_o), 32'd0);
      tick();
      chk({nm, "_sv_done"}, 32'(sharers_v_o), 32'd1);
      chk({nm, "_rdy_done"}, 32'(rd_ready_o), 32'd1);
   endtask

   task automatic chk_vec(input string nm, input logic [3:0] h, input logic [11:0] w, input logic [11:0] s);
      chk({nm, "_hits"}, 32'(sharers_hits_o), 32'(h));
      chk({nm, "_ways"}, 32'(sharers_ways_o), 32'(w));
      chk({nm, "_states"}, 32'(sharers_coh_states_o), 32'(s));
   endtask

   initial begin
      logic [2:0] fs;
      // filler: distinct valid tags in 0x200..0x2FF, never any tag under test
      for (int a = 0; a < 32; a++) begin
         for (int w = 0; w < NA; w++) begin
            case ((a + w) % 3)
               0:       fs = 3'b001;
               1:       fs = 3'b010;
               default: fs = 3'b110;
            endcase
            set_entry(a, w, 10'h200 | 10'(a * 8 + w), fs);
         end
      end
      set_entry(21, 3, 10'h02A, 3'b010);
      set_entry(20, 5, 10'h02A, 3'b000);
      set_entry(8,  2, 10'h02A, 3'b000);
      set_entry(8,  6, 10'h02A, 3'b001);
      set_entry(10, 0, 10'h02B, 3'b110);
      set_entry(14, 1, 10'h155, 3'b110);
      set_entry(14, 4, 10'h155, 3'b110);
      set_entry(15, 7, 10'h155, 3'b111);
      set_entry(12, 0, 10'h154, 3'b110);

      ram_data_i = '0;
      rd_v_i     = 1'b0;
      wg_id_i    = '0;
      tag_i      = '0;
      reset_i    = 1'b1;
      #1;
      chk("rst_ready", 32'(rd_ready_o), 32'd1);
      chk("rst_ram_v", 32'(ram_v_o), 32'd0);
      chk("rst_addr", 32'(ram_addr_o), 32'd0);
      chk("rst_sv", 32'(sharers_v_o), 32'd0);
      chk_vec("rst", 4'h0, 12'h000, 12'h000);
      tick();
      tick();
      reset_i = 1'b0;
      tick();
      chk("idle_ready", 32'(rd_ready_o), 32'd1);
      chk("idle_ram_v", 32'(ram_v_o), 32'd0);
      chk("idle_sv", 32'(sharers_v_o), 32'd0);

      // LCE1 way3 holds 0x2A in E
      start_req(3'd5, 10'h02A);
      run_burst("t1", 20);
      chk_vec("t1", 4'b0010, 12'h018, 12'h010);

      // LCE0: way2 matches in I (ignored), way6 matches in S
      start_req(3'd2, 10'h02A);
      chk("t2_not_ready", 32'(rd_ready_o), 32'd0);
      run_burst("t2", 8);
      chk_vec("t2", 4'b0001, 12'h006, 12'h001);

      // LCE2 ways 1 and 4 in M (way1 wins); LCE3 way7 in O
      start_req(3'd3, 10'h155);
      run_burst("t3", 12);
      chk_vec("t3", 4'b1100, 12'hE40, 12'hF80);

      // back-to-back acceptance on the first sharers_v cycle
      rd_v_i  = 1'b1;
      wg_id_i = 3'd5;
      tag_i   = 10'h02A;
      tick();
      rd_v_i  = 1'b0;
      chk("b2b_sv_low", 32'(sharers_v_o), 32'd0);
      chk("b2b_cleared", 32'(sharers_hits_o), 32'd0);
      run_burst("b2b", 20);
      chk_vec("b2b", 4'b0010, 12'h018, 12'h010);

      // reset during cycle 3 of a read
      start_req(3'd2, 10'h02A);
      tick();
      tick();
      chk("mid_partial", 32'(sharers_hits_o), 32'd1);
      reset_i = 1'b1;
      #1;
      chk("mid_rst_ram_v", 32'(ram_v_o), 32'd0);
      chk("mid_rst_ready", 32'(rd_ready_o), 32'd1);
      chk("mid_rst_sv", 32'(sharers_v_o), 32'd0);
      chk_vec("mid_rst", 4'h0, 12'h000, 12'h000);
      tick();
      reset_i = 1'b0;
      tick();
      start_req(3'd2, 10'h02A);
      run_burst("post_rst", 8);
      chk_vec("post_rst", 4'b0001, 12'h006, 12'h001);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
